// File: rtl/lock_key_loader_if.sv
// Key-storage word stream: one word per accepted valid/ready transfer.
interface lock_key_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] kdat;
    logic              kdat_valid;
    logic              kdat_ready;

    modport master (output kdat, output kdat_valid, input kdat_ready);
    modport slave  (input kdat, input kdat_valid, output kdat_ready);
endinterface

// File: rtl/lock_key_loader.sv
// Stages the c432 unlock key from a word stream into a shadow register and
// drives the netlist key inputs only once the trailing XOR checksum matches.
module lock_key_loader #(
    parameter int MUX_KEY_W = 32,
    parameter int XOR_KEY_W = 11,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    lock_key_loader_if.slave     kif,
    output logic [MUX_KEY_W-1:0] key_p,
    output logic [XOR_KEY_W-1:0] key_x,
    output logic                 key_valid,
    output logic                 busy,
    output logic [1:0]           err
);
    localparam int KEY_W  = MUX_KEY_W + XOR_KEY_W;
    localparam int NWORDS = (KEY_W + WORD_W - 1) / WORD_W;
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK} state_t;

    state_t                state_q, state_d;
    logic [KEY_W-1:0]      shadow_q, shadow_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [WORD_W-1:0]     xor_q, xor_d;
    logic [WORD_W-1:0]     csum_q, csum_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [MUX_KEY_W-1:0]  key_p_q, key_p_d;
    logic [XOR_KEY_W-1:0]  key_x_q, key_x_d;
    logic                  key_valid_q, key_valid_d;
    logic [1:0]            err_q, err_d;
    logic                  ready;
    logic                  transfer;

    assign ready          = (state_q == S_LOAD);
    assign transfer       = kif.kdat_valid && ready;
    assign kif.kdat_ready = ready;
    assign busy           = (state_q != S_IDLE);
    assign key_p          = key_p_q;
    assign key_x          = key_x_q;
    assign key_valid      = key_valid_q;
    assign err            = err_q;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        wcnt_d      = wcnt_q;
        xor_d       = xor_q;
        csum_d      = csum_q;
        idle_d      = idle_q;
        key_p_d     = key_p_q;
        key_x_d     = key_x_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    wcnt_d      = '0;
                    xor_d       = '0;
                    idle_d      = '0;
                    key_valid_d = 1'b0;
                    err_d       = ERR_NONE;
                end
            end
            S_LOAD: begin
                if (transfer) begin
                    idle_d = '0;
                    if (wcnt_q < WCNT_W'(NWORDS)) begin
                        // Bits of the last word that fall at or above KEY_W are dropped here.
                        for (int i = 0; i < KEY_W; i++) begin
                            if (i / WORD_W == int'(wcnt_q)) shadow_d[i] = kif.kdat[i % WORD_W];
                        end
                        xor_d  = xor_q ^ kif.kdat;
                        wcnt_d = wcnt_q + 1'b1;
                    end else begin
                        csum_d  = kif.kdat;
                        state_d = S_CHECK;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    key_p_d     = '0;
                    key_x_d     = '0;
                    key_valid_d = 1'b0;
                    err_d       = ERR_TIMEOUT;
                    state_d     = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (xor_q == csum_q) begin
                    key_p_d     = shadow_q[MUX_KEY_W-1:0];
                    key_x_d     = shadow_q[KEY_W-1:MUX_KEY_W];
                    key_valid_d = 1'b1;
                end else begin
                    key_p_d     = '0;
                    key_x_d     = '0;
                    key_valid_d = 1'b0;
                    err_d       = ERR_CHECKSUM;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Zeroize overrides everything, including a coincident start.
        if (clear) begin
            state_d     = S_IDLE;
            shadow_d    = '0;
            wcnt_d      = '0;
            xor_d       = '0;
            idle_d      = '0;
            key_p_d     = '0;
            key_x_d     = '0;
            key_valid_d = 1'b0;
            err_d       = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            wcnt_q      <= '0;
            xor_q       <= '0;
            csum_q      <= '0;
            idle_q      <= '0;
            key_p_q     <= '0;
            key_x_q     <= '0;
            key_valid_q <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            wcnt_q      <= wcnt_d;
            xor_q       <= xor_d;
            csum_q      <= csum_d;
            idle_q      <= idle_d;
            key_p_q     <= key_p_d;
            key_x_q     <= key_x_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: table of whole key loads plus hand-written
// sequences for reload, clear, start-while-busy and asynchronous reset.
module tb_lock_key_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [31:0] key_p;
    logic [10:0] key_x;
    logic        key_valid;
    logic        busy;
    logic [1:0]  err;

    int errors = 0;
    int checks = 0;

    lock_key_loader_if #(.WORD_W(8)) kif ();

    lock_key_loader #(
        .MUX_KEY_W(32),
        .XOR_KEY_W(11),
        .WORD_W   (8),
        .TIMEOUT  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear    (clear),
        .kif      (kif),
        .key_p    (key_p),
        .key_x    (key_x),
        .key_valid(key_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // words[8*i +: 8] is stream word i; word 6 is the checksum.
    typedef struct packed {
        logic [55:0] words;
        logic [7:0]  gap;
        logic [31:0] exp_p;
        logic [10:0] exp_x;
        logic        exp_v;
        logic [1:0]  exp_e;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    localparam logic [55:0] GOOD_A5 = 56'h50_05_55_A5A5A5A5;
    localparam logic [55:0] BAD_A5  = 56'h51_05_55_A5A5A5A5;

    function automatic vec_t mk(input logic [55:0] w, input logic [7:0] g, input logic [31:0] p,
                                input logic [10:0] x, input logic v, input logic [1:0] e);
        vec_t r;
        r.words = w;
        r.gap   = g;
        r.exp_p = p;
        r.exp_x = x;
        r.exp_v = v;
        r.exp_e = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] w, input int gap, output bit ok);
        kif.kdat_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        if (kif.kdat_ready !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        kif.kdat       = w;
        kif.kdat_valid = 1'b1;
        tick();
        kif.kdat_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic feed_range(input logic [55:0] words, input int first, input int last,
                              input int gap, output int n);
        bit ok;
        n = 0;
        for (int i = first; i <= last; i++) begin
            feed(words[8*i +: 8], gap, ok);
            if (!ok) return;
            n++;
        end
    endtask

    task automatic send_load(input logic [55:0] words, input int gap, output int n);
        do_start();
        feed_range(words, 0, 6, gap, n);
    endtask

    task automatic check_good_a5(input string tag);
        check({tag, "_p"}, 64'(key_p), 64'hA5A5A5A5);
        check({tag, "_x"}, 64'(key_x), 64'h555);
        check({tag, "_v"}, 64'(key_valid), 64'd1);
        check({tag, "_e"}, 64'(err), 64'd0);
    endtask

    task automatic check_zero(input string tag, input logic [1:0] exp_e);
        check({tag, "_p"}, 64'(key_p), 64'd0);
        check({tag, "_x"}, 64'(key_x), 64'd0);
        check({tag, "_v"}, 64'(key_valid), 64'd0);
        check({tag, "_e"}, 64'(err), 64'(exp_e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = mk(GOOD_A5, 8'd0, 32'hA5A5A5A5, 11'h555, 1'b1, 2'd0);
        vecs[1] = mk(BAD_A5, 8'd0, 32'h0, 11'h0, 1'b0, 2'd1);
        vecs[2] = mk(GOOD_A5, 8'd3, 32'hA5A5A5A5, 11'h555, 1'b1, 2'd0);
        vecs[3] = mk(GOOD_A5, 8'd4, 32'h0, 11'h0, 1'b0, 2'd2);
        vecs[4] = mk(56'hFC_07_FF_04030201, 8'd0, 32'h04030201, 11'h7FF, 1'b1, 2'd0);
        vecs[5] = mk(56'hF9_F9_00_00000000, 8'd1, 32'h0, 11'h100, 1'b1, 2'd0);

        rst_n          = 1'b0;
        start          = 1'b0;
        clear          = 1'b0;
        kif.kdat       = '0;
        kif.kdat_valid = 1'b0;
        #12;
        check_zero("rst", 2'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(kif.kdat_ready), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        for (int r = 0; r < NV; r++) begin
            send_load(vecs[r].words, int'(vecs[r].gap), n);
            if (n == 7) begin
                check($sformatf("r%0d_lat_v", r), 64'(key_valid), 64'd0);
                check($sformatf("r%0d_lat_busy", r), 64'(busy), 64'd1);
                tick();
            end
            check($sformatf("r%0d_p", r), 64'(key_p), 64'(vecs[r].exp_p));
            check($sformatf("r%0d_x", r), 64'(key_x), 64'(vecs[r].exp_x));
            check($sformatf("r%0d_v", r), 64'(key_valid), 64'(vecs[r].exp_v));
            check($sformatf("r%0d_e", r), 64'(err), 64'(vecs[r].exp_e));
            check($sformatf("r%0d_busy", r), 64'(busy), 64'd0);
            tick();
        end

        // Reload with a bad checksum: old key holds through the load.
        send_load(GOOD_A5, 0, n);
        tick();
        check_good_a5("pre_reload");
        do_start();
        check("reload_v_drop", 64'(key_valid), 64'd0);
        check("reload_hold_p0", 64'(key_p), 64'hA5A5A5A5);
        feed_range(BAD_A5, 0, 2, 0, n);
        check("reload_hold_p1", 64'(key_p), 64'hA5A5A5A5);
        check("reload_hold_x1", 64'(key_x), 64'h555);
        feed_range(BAD_A5, 3, 6, 0, n);
        tick();
        check_zero("reload_bad", 2'd1);
        check("reload_busy", 64'(busy), 64'd0);

        // Clear after three words, on top of a committed key.
        send_load(GOOD_A5, 0, n);
        tick();
        do_start();
        feed_range(GOOD_A5, 0, 2, 0, n);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_zero("clear", 2'd0);
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_ready", 64'(kif.kdat_ready), 64'd0);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clear_wins_busy", 64'(busy), 64'd0);
        send_load(GOOD_A5, 0, n);
        tick();
        check_good_a5("after_clear");

        // Start pulse in the middle of a load must not restart the word count.
        do_start();
        feed_range(GOOD_A5, 0, 1, 0, n);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_range(GOOD_A5, 2, 6, 0, n);
        check("busy_start_n", 64'(n), 64'd5);
        tick();
        check_good_a5("busy_start");

        // Asynchronous reset between edges mid-load.
        do_start();
        feed_range(GOOD_A5, 0, 1, 0, n);
        #3 rst_n = 1'b0;
        #1;
        check_zero("async_rst", 2'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_ready", 64'(kif.kdat_ready), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        check_zero("post_rst", 2'd0);
        send_load(GOOD_A5, 0, n);
        tick();
        check_good_a5("post_rst_load");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
